// File: rtl/tsc_pkg.sv
// Shared definitions for the 16-bit TSC CPU front end (fetch and decode).
package tsc_pkg;

    localparam int              WORD_W   = 16;
    localparam logic [15:0]     RESET_PC = 16'h0000;

    // Fetch controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    // HLT is an R-type instruction: opcode 15 with function code 29.
    localparam logic [3:0] OPC_RTYPE = 4'd15;
    localparam logic [5:0] FUNC_HLT  = 6'd29;

    function automatic logic is_hlt(input logic [15:0] instr);
        return (instr[15:12] == OPC_RTYPE) && (instr[5:0] == FUNC_HLT);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter for the fetch stage: redirect load has priority over the
// sequential increment; arithmetic wraps modulo 2^WORD_W.
module fetch_pc_reg
    import tsc_pkg::*;
#(
    parameter int                WORD_W   = 16,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_inc,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_load_pc,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_pc_inc
);

    localparam logic [WORD_W-1:0] ONE = {{(WORD_W-1){1'b0}}, 1'b1};

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + ONE;
    assign o_pc     = r_pc;
    assign o_pc_inc = w_pc_inc;

    // PC register: redirect target wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= w_pc_inc;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the TSC CPU: PC ownership, instruction-memory read
// handshake, hold-until-accepted buffer for decode, redirect and halt.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | i_readM asserted, waiting for i_inputReady
// HOLD  | instruction held valid until decode accepts or a redirect squashes it
// HALT  | fetch stopped; only reset leaves
module instr_fetch_unit #(
    parameter int                WORD_W   = tsc_pkg::WORD_W,
    parameter logic [WORD_W-1:0] RESET_PC = tsc_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              i_readM,
    output logic [WORD_W-1:0] i_address,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_inputReady,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              dec_ready,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [WORD_W-1:0] num_inst,
    output logic              halted
);

    import tsc_pkg::*;

    localparam logic [WORD_W-1:0] ONE = {{(WORD_W-1){1'b0}}, 1'b1};

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;

    logic [WORD_W-1:0] r_address;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic [WORD_W-1:0] r_num_inst;
    // Set when a redirect lands while a request is outstanding: the response
    // that eventually arrives belongs to the old path and must be dropped.
    logic              r_squash;
    // Halt seen during REQ; the transaction still has to complete.
    logic              r_halt_pend;

    logic [WORD_W-1:0] w_pc;
    logic [WORD_W-1:0] w_pc_inc;
    logic              w_pc_inc_en;
    logic              w_pc_load;
    logic              w_addr_load;
    logic [WORD_W-1:0] w_addr_val;
    logic              w_capture;
    logic              w_valid_clr;
    logic              w_cnt_inc;
    logic              w_squash_set;
    logic              w_squash_clr;
    logic              w_halt_pend_set;

    fetch_pc_reg #(
        .WORD_W   (WORD_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_inc     (w_pc_inc_en),
        .i_load    (w_pc_load),
        .i_load_pc (redirect_pc),
        .o_pc      (w_pc),
        .o_pc_inc  (w_pc_inc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control; priority is halt > redirect > dec_ready.
    always_comb begin
        w_state_next    = r_state;
        w_pc_inc_en     = 1'b0;
        w_pc_load       = 1'b0;
        w_addr_load     = 1'b0;
        w_addr_val      = w_pc;
        w_capture       = 1'b0;
        w_valid_clr     = 1'b0;
        w_cnt_inc       = 1'b0;
        w_squash_set    = 1'b0;
        w_squash_clr    = 1'b0;
        w_halt_pend_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (halt) begin
                    w_state_next = ST_HALT;
                    w_valid_clr  = 1'b1;
                end else begin
                    w_state_next = ST_REQ;
                    w_addr_load  = 1'b1;
                    w_addr_val   = w_pc;
                end
            end
            ST_REQ: begin
                if (i_inputReady) begin
                    if (halt || r_halt_pend) begin
                        w_state_next = ST_HALT;
                    end else if (redirect) begin
                        // Same-cycle redirect: drop data, re-request at target.
                        w_pc_load    = 1'b1;
                        w_addr_load  = 1'b1;
                        w_addr_val   = redirect_pc;
                        w_squash_clr = 1'b1;
                    end else if (r_squash) begin
                        w_squash_clr = 1'b1;
                        w_addr_load  = 1'b1;
                        w_addr_val   = w_pc;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end else if (halt || r_halt_pend) begin
                    w_halt_pend_set = 1'b1;
                end else if (redirect) begin
                    // Address must stay put until the memory answers.
                    w_pc_load    = 1'b1;
                    w_squash_set = 1'b1;
                end
            end
            ST_HOLD: begin
                if (halt) begin
                    w_state_next = ST_HALT;
                    w_valid_clr  = 1'b1;
                end else if (redirect) begin
                    w_pc_load    = 1'b1;
                    w_addr_load  = 1'b1;
                    w_addr_val   = redirect_pc;
                    w_valid_clr  = 1'b1;
                    w_state_next = ST_REQ;
                end else if (dec_ready) begin
                    w_cnt_inc    = 1'b1;
                    w_pc_inc_en  = 1'b1;
                    w_addr_load  = 1'b1;
                    w_addr_val   = w_pc_inc;
                    w_valid_clr  = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request address and the instruction buffer handed to decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_address     <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_addr_load) begin
                r_address <= w_addr_val;
            end
            if (w_capture) begin
                r_instr       <= i_data;
                r_instr_pc    <= r_address;
                r_instr_valid <= 1'b1;
            end else if (w_valid_clr) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    // Accepted-instruction counter, wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_inst <= '0;
        end else if (w_cnt_inc) begin
            r_num_inst <= r_num_inst + ONE;
        end
    end

    // Squash and pending-halt flags for the outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_squash    <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            if (w_squash_clr) begin
                r_squash <= 1'b0;
            end else if (w_squash_set) begin
                r_squash <= 1'b1;
            end
            if (w_halt_pend_set) begin
                r_halt_pend <= 1'b1;
            end
        end
    end

    assign i_readM     = (r_state == ST_REQ);
    assign halted      = (r_state == ST_HALT);
    assign i_address   = r_address;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign num_inst    = r_num_inst;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// scored against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_inputReady;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        dec_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] num_inst;
    logic        halted;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_readM      (i_readM),
        .i_address    (i_address),
        .i_data       (i_data),
        .i_inputReady (i_inputReady),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .dec_ready    (dec_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .num_inst     (num_inst),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents used by the randomized run: a fixed scramble of the address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        i_data       = '0;
        i_inputReady = 1'b0;
        dec_ready    = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        halt         = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Return one word for the outstanding request; leaves the unit in HOLD.
    task automatic respond(input logic [15:0] d);
        i_inputReady = 1'b1;
        i_data       = d;
        tick();
        i_inputReady = 1'b0;
    endtask

    task automatic accept;
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (i_readM !== 1'b0) begin errors++; $display("FAIL rst_readM got %b exp 0", i_readM); end
        checks++; if (i_address !== 16'h0) begin errors++; $display("FAIL rst_addr got %h exp 0000", i_address); end
        checks++; if (instr !== 16'h0 || instr_pc !== 16'h0) begin errors++; $display("FAIL rst_instr got %h/%h exp 0000/0000", instr, instr_pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++; if (num_inst !== 16'h0 || halted !== 1'b0) begin errors++; $display("FAIL rst_cnt_halt got %h/%b exp 0000/0", num_inst, halted); end
        reset_n = 1'b1;
        checks++; if (i_readM !== 1'b0) begin errors++; $display("FAIL idle_readM got %b exp 0", i_readM); end
        tick();
    endtask

    task automatic test_first_fetch;
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0000) begin errors++; $display("FAIL first_req got %b/%h exp 1/0000", i_readM, i_address); end
        respond(16'h6A05);
        checks++; if (instr !== 16'h6A05 || instr_pc !== 16'h0000 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL first_hold got %h/%h/%b exp 6a05/0000/1", instr, instr_pc, instr_valid); end
        checks++; if (i_readM !== 1'b0) begin errors++; $display("FAIL first_hold_readM got %b exp 0", i_readM); end
        accept();
        checks++; if (i_address !== 16'h0001 || num_inst !== 16'h0001 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL first_accept got %h/%h/%b exp 0001/0001/0", i_address, num_inst, instr_valid); end
    endtask

    task automatic test_mem_wait;
        for (int k = 1; k < 4; k++) begin
            respond(16'h1000 + 16'(k));
            accept();
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (i_readM !== 1'b1 || i_address !== 16'h0004 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL wait_stable got %b/%h/%b exp 1/0004/0", i_readM, i_address, instr_valid); end
            tick();
        end
        respond(16'h1234);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0004 || instr !== 16'h1234) begin
            errors++; $display("FAIL wait_hold got %b/%h/%h exp 1/0004/1234", instr_valid, instr_pc, instr); end
        tick();
        checks++; if (i_readM !== 1'b0 || num_inst !== 16'h0004) begin
            errors++; $display("FAIL wait_nodup got %b/%h exp 0/0004", i_readM, num_inst); end
        accept();
        checks++; if (i_address !== 16'h0005 || num_inst !== 16'h0005) begin
            errors++; $display("FAIL wait_accept got %h/%h exp 0005/0005", i_address, num_inst); end
    endtask

    task automatic test_hold_redirect;
        redirect = 1'b1; redirect_pc = 16'h0010; i_inputReady = 1'b1; i_data = 16'hFFFF;
        tick();
        clear_inputs();
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0010 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL redir_rdy got %b/%h/%b exp 1/0010/0", i_readM, i_address, instr_valid); end
        respond(16'hBEEF);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (instr !== 16'hBEEF || instr_pc !== 16'h0010 || instr_valid !== 1'b1 || num_inst !== 16'h0005) begin
                errors++; $display("FAIL hold_stable got %h/%h/%b/%h exp beef/0010/1/0005", instr, instr_pc, instr_valid, num_inst); end
        end
        redirect = 1'b1; redirect_pc = 16'h0040; dec_ready = 1'b1;
        tick();
        clear_inputs();
        checks++; if (instr_valid !== 1'b0 || num_inst !== 16'h0005 || i_address !== 16'h0040 || i_readM !== 1'b1) begin
            errors++; $display("FAIL hold_squash got %b/%h/%h/%b exp 0/0005/0040/1", instr_valid, num_inst, i_address, i_readM); end
    endtask

    task automatic test_req_redirect;
        redirect = 1'b1; redirect_pc = 16'h0020; i_inputReady = 1'b1;
        tick();
        clear_inputs();
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        clear_inputs();
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0020) begin
            errors++; $display("FAIL req_redir_hold got %b/%h exp 1/0020", i_readM, i_address); end
        respond(16'hDEAD);
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0100 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL req_redir_drop got %b/%h/%b exp 1/0100/0", i_readM, i_address, instr_valid); end
        respond(16'h0ABC);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || instr !== 16'h0ABC) begin
            errors++; $display("FAIL req_redir_new got %b/%h/%h exp 1/0100/0abc", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_wrap;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        clear_inputs();
        checks++; if (i_address !== 16'hFFFF) begin errors++; $display("FAIL wrap_req got %h exp ffff", i_address); end
        respond(16'h7777);
        checks++; if (instr_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_hold got %h exp ffff", instr_pc); end
        accept();
        checks++; if (i_address !== 16'h0000 || num_inst !== 16'h0006) begin
            errors++; $display("FAIL wrap_next got %h/%h exp 0000/0006", i_address, num_inst); end
    endtask

    task automatic test_halt_req;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++; if (i_readM !== 1'b1 || halted !== 1'b0 || i_address !== 16'h0000) begin
            errors++; $display("FAIL halt_req_wait got %b/%b/%h exp 1/0/0000", i_readM, halted, i_address); end
        tick();
        respond(16'h1111);
        checks++; if (halted !== 1'b1 || i_readM !== 1'b0 || instr_valid !== 1'b0 || num_inst !== 16'h0006) begin
            errors++; $display("FAIL halt_req_done got %b/%b/%b/%h exp 1/0/0/0006", halted, i_readM, instr_valid, num_inst); end
        for (int k = 0; k < 3; k++) begin
            redirect = 1'b1; redirect_pc = 16'h0300; i_inputReady = 1'b1; dec_ready = 1'b1;
            tick();
            checks++; if (halted !== 1'b1 || i_readM !== 1'b0 || num_inst !== 16'h0006) begin
                errors++; $display("FAIL halt_sticky got %b/%b/%h exp 1/0/0006", halted, i_readM, num_inst); end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset;
        do_reset();
        tick();
        respond(16'h2222);
        accept();
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (i_readM !== 1'b0 || i_address !== 16'h0 || num_inst !== 16'h0 || instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0 || halted !== 1'b0) begin
            errors++; $display("FAIL async_rst got %b/%h/%h/%b/%h/%h/%b exp all zero", i_readM, i_address, num_inst, instr_valid, instr, instr_pc, halted); end
        i_inputReady = 1'b1; i_data = 16'h9999;
        @(negedge clk);
        i_inputReady = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0000 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL async_restart got %b/%h/%b exp 1/0000/0", i_readM, i_address, instr_valid); end
        respond(16'h4242);
        checks++; if (instr !== 16'h4242 || instr_pc !== 16'h0000) begin
            errors++; $display("FAIL async_first got %h/%h exp 4242/0000", instr, instr_pc); end
    endtask

    task automatic test_halt_idle_hold;
        do_reset();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++; if (halted !== 1'b1 || i_readM !== 1'b0) begin
            errors++; $display("FAIL halt_idle got %b/%b exp 1/0", halted, i_readM); end
        do_reset();
        tick();
        respond(16'h3333);
        halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0050; dec_ready = 1'b1;
        tick();
        clear_inputs();
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || num_inst !== 16'h0 || i_readM !== 1'b0) begin
            errors++; $display("FAIL halt_hold got %b/%b/%h/%b exp 1/0/0000/0", halted, instr_valid, num_inst, i_readM); end
    endtask

    // Transaction-level model: the stream of instructions presented to decode
    // must be sequential from RESET_PC, restarting at each redirect target, and
    // each word must be the memory content at its address.
    task automatic test_random;
        logic [15:0] exp_pc;
        logic [15:0] exp_cnt;
        logic        prev_valid;
        logic        prev_req;
        logic        prev_done;
        logic [15:0] prev_addr;
        int          mem_wait;
        int          presented;
        do_reset();
        exp_pc     = 16'h0000;
        exp_cnt    = 16'h0000;
        prev_valid = 1'b0;
        prev_req   = 1'b0;
        prev_done  = 1'b0;
        prev_addr  = '0;
        mem_wait   = 0;
        presented  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (num_inst !== exp_cnt || halted !== 1'b0) begin
                errors++; $display("FAIL rnd_count cyc %0d got %h/%b exp %h/0", cyc, num_inst, halted, exp_cnt); end
            if (instr_valid && !prev_valid) begin
                presented++;
                checks++; if (instr_pc !== exp_pc || instr !== memf(instr_pc)) begin
                    errors++; $display("FAIL rnd_instr cyc %0d got %h@%h exp %h@%h", cyc, instr, instr_pc, memf(exp_pc), exp_pc); end
            end
            if (i_readM && prev_req && !prev_done) begin
                checks++; if (i_address !== prev_addr) begin
                    errors++; $display("FAIL rnd_addr_stable cyc %0d got %h exp %h", cyc, i_address, prev_addr); end
            end
            if (i_readM) begin
                if (mem_wait == 0) begin
                    i_inputReady = 1'b1;
                    i_data       = memf(i_address);
                    mem_wait     = $urandom_range(0, 3);
                end else begin
                    i_inputReady = 1'b0;
                    i_data       = 16'($urandom);
                    mem_wait--;
                end
            end else begin
                i_inputReady = ($urandom_range(0, 3) == 0);
                i_data       = 16'($urandom);
            end
            dec_ready   = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = 16'($urandom);
            if (redirect && (i_readM || instr_valid)) begin
                exp_pc = redirect_pc;
            end else if (instr_valid && dec_ready) begin
                exp_pc  = exp_pc + 16'h0001;
                exp_cnt = exp_cnt + 16'h0001;
            end
            prev_valid = instr_valid;
            prev_req   = i_readM;
            prev_done  = i_inputReady;
            prev_addr  = i_address;
            tick();
        end
        clear_inputs();
        checks++; if (presented < 100) begin
            errors++; $display("FAIL rnd_progress got %0d exp >= 100", presented); end
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_mem_wait();
        test_hold_redirect();
        test_req_redirect();
        test_wrap();
        test_halt_req();
        test_async_reset();
        test_halt_idle_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
